// File: rtl/morph_pkg.sv
// Shared types and helpers for the 3x3 grey-scale morphology front end.
// The max3/min3 helpers are reused by the edge-enhancer bench.
package morph_pkg;

  localparam int PIX_W_DEF = 8;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    pix_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    pix_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// One-line delay: the word read at a column address is the one written there
// DEPTH advances earlier; it is replaced by din on the same advance.
module morph_line_buffer #(
  parameter int DEPTH = 640,
  parameter int PIX_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             adv,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // NOTE: memories are deliberately not reset; stale contents only ever land in
  // out-of-image taps, which the border mask replaces with the centre pixel.
  always_ff @(posedge clk) begin
    if (adv) mem[addr] <= din;
  end

endmodule

// File: rtl/morph_minmax_3x3.sv
// Streaming 3x3 dilation/erosion producing {centre, max, min} triples.
// Build option: define MORPH_CROSS_SE_EN to use a cross element instead of the full square.
module morph_minmax_3x3
  import morph_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic [PIX_W-1:0] out_dilate,
  output logic [PIX_W-1:0] out_erode,
  output logic             out_sof,
  output logic             out_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
`ifdef MORPH_CROSS_SE_EN
  localparam bit CROSS_SE = 1'b1;
`else
  localparam bit CROSS_SE = 1'b0;
`endif

  state_e           state, state_nxt;
  logic             run_en;
  logic [CW-1:0]    in_col, out_col;
  logic [RW-1:0]    in_row, out_row;
  logic [PIX_W-1:0] shift_in, lb1_q, lb2_q, ctr, dil, ero;
  // Tap index [row][col]: row 0 = line below centre, 2 = above; col 0 = right, 2 = left.
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] nwin [3][3];
  logic [PIX_W-1:0] mwin [3][3];
  logic [PIX_W-1:0] rmax [3];
  logic [PIX_W-1:0] rmin [3];
  logic             out_free, fire_in, flush_step, adv, emit, last_in, fill_done, keep;

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = run_en && (state != FLUSH) && out_free;
  assign fire_in    = in_valid && in_ready;
  assign flush_step = (state == FLUSH) && out_free && !(out_valid && out_eof);
  assign adv        = fire_in || flush_step;
  assign last_in    = (in_row == ROW_LAST) && (in_col == COL_LAST);
  // Pixel (1,1) completes the window of (0,0).
  assign fill_done  = (in_row == RW'(1)) && (in_col == CW'(1));
  assign emit       = adv && ((state != FILL) || fill_done);
  assign shift_in   = (state == FLUSH) ? '0 : in_pixel;

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: if (fire_in) begin
        if (last_in)        state_nxt = FLUSH;
        else if (fill_done) state_nxt = RUN;
      end
      RUN:   if (fire_in && last_in) state_nxt = FLUSH;
      FLUSH: if (out_valid && out_ready && out_eof) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      run_en  <= 1'b0;
      in_col  <= '0;
      in_row  <= '0;
      out_col <= '0;
      out_row <= '0;
    end else begin
      state  <= state_nxt;
      run_en <= 1'b1;
      if ((state == FLUSH) && (state_nxt == FILL)) begin
        in_col <= '0;
        in_row <= '0;
      end else if (adv) begin
        in_col <= (in_col == COL_LAST) ? '0 : in_col + CW'(1);
        if (in_col == COL_LAST) in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
      end
      if (emit) begin
        out_col <= (out_col == COL_LAST) ? '0 : out_col + CW'(1);
        if (out_col == COL_LAST) out_row <= (out_row == ROW_LAST) ? '0 : out_row + RW'(1);
      end
    end
  end

  morph_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb1 (
    .clk(clk), .adv(adv), .addr(in_col), .din(shift_in), .dout(lb1_q)
  );

  morph_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb2 (
    .clk(clk), .adv(adv), .addr(in_col), .din(lb1_q), .dout(lb2_q)
  );

  // The window as it will stand after this advance; its centre is (out_row, out_col).
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 1; j < 3; j++) nwin[i][j] = win[i][j-1];
    end
    nwin[0][0] = shift_in;
    nwin[1][0] = lb1_q;
    nwin[2][0] = lb2_q;
  end

  always_ff @(posedge clk) begin
    if (adv) win <= nwin;
  end

  // NOTE: every always_comb output gets a value on every path (default first),
  // otherwise synthesis infers latches.
  always_comb begin
    ctr  = nwin[1][1];
    keep = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        keep = 1'b1;
        if (i == 2 && out_row == '0)      keep = 1'b0;
        if (i == 0 && out_row == ROW_LAST) keep = 1'b0;
        if (j == 2 && out_col == '0)      keep = 1'b0;
        if (j == 0 && out_col == COL_LAST) keep = 1'b0;
        if (CROSS_SE && i != 1 && j != 1) keep = 1'b0;
        mwin[i][j] = keep ? nwin[i][j] : ctr;
      end
      rmax[i] = max3(mwin[i][0], mwin[i][1], mwin[i][2]);
      rmin[i] = min3(mwin[i][0], mwin[i][1], mwin[i][2]);
    end
    dil = max3(rmax[0], rmax[1], rmax[2]);
    ero = min3(rmin[0], rmin[1], rmin[2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_dilate <= '0;
      out_erode  <= '0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_pixel  <= ctr;
      out_dilate <= dil;
      out_erode  <= ero;
      out_sof    <= (out_row == '0) && (out_col == '0);
      out_eof    <= (out_row == ROW_LAST) && (out_col == COL_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_morph_minmax_3x3.sv
// Self-checking bench for morph_minmax_3x3 on a 4x3 image with a scoreboard of
// expected triples computed directly from the neighbourhood definition.
module tb_morph_minmax_3x3;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef logic [7:0] frame_t [N];
  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] dil;
    logic [7:0] ero;
    logic       sof;
    logic       eof;
  } trip_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pixel, out_dilate, out_erode;
  logic       out_sof, out_eof;

  int    n_tests = 0;
  int    n_fails = 0;
  int    beat_cnt = 0;
  int    ready_mode = 0;
  trip_t exp_q [$];
  trip_t rx [256];
  bit    prev_stall = 1'b0;
  trip_t held;

  always #5 clk = ~clk;

  morph_minmax_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_dilate(out_dilate), .out_erode(out_erode),
    .out_sof(out_sof), .out_eof(out_eof)
  );

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else                 out_ready = ~out_ready;
  end

  function automatic trip_t model(input frame_t f, input int r, input int c);
    trip_t t;
    int rr, cc;
    logic [7:0] v;
    t.pix = f[r*W + c];
    t.dil = t.pix;
    t.ero = t.pix;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
`ifdef MORPH_CROSS_SE_EN
          if (dr == 0 || dc == 0) begin
`else
          begin
`endif
            v = f[rr*W + cc];
            if (v > t.dil) t.dil = v;
            if (v < t.ero) t.ero = v;
          end
        end
      end
    end
    t.sof = (r == 0 && c == 0);
    t.eof = (r == H-1 && c == W-1);
    return t;
  endfunction

  task automatic push_frame(input frame_t f);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(model(f, r, c));
  endtask

  // Scoreboard and hold-while-stalled monitor, sampled on the falling edge.
  always @(negedge clk) begin
    trip_t cur, e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      cur = '{pix: out_pixel, dil: out_dilate, ero: out_erode, sof: out_sof, eof: out_eof};
      if (prev_stall) begin
        n_tests++;
        if (!out_valid || cur !== held) begin
          n_fails++;
          $display("FAIL stall_hold: got valid=%0b triple=%h, want valid=1 triple=%h", out_valid, cur, held);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL extra_triple beat %0d: got %h, want no output", beat_cnt, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fails++;
            $display("FAIL triple beat %0d: got pix=%0d dil=%0d ero=%0d sof=%0b eof=%0b, want pix=%0d dil=%0d ero=%0d sof=%0b eof=%0b",
                     beat_cnt, cur.pix, cur.dil, cur.ero, cur.sof, cur.eof, e.pix, e.dil, e.ero, e.sof, e.eof);
          end
        end
        if (beat_cnt < 256) rx[beat_cnt] = cur;
        beat_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      held = cur;
    end
  end

  task automatic drive_pixels(input frame_t f, input int n_pix, input int gap_pct);
    bit acc;
    int cyc;
    for (int k = 0; k < n_pix; k++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_pixel = f[k];
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        cyc++;
      end
      if (!acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input frame_t f, input int gap_pct, output int base);
    base = beat_cnt;
    push_frame(f);
    drive_pixels(f, N, gap_pct);
    drain();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got valid=%0b ready=%0b sof=%0b eof=%0b, want all 0", out_valid, in_ready, out_sof, out_eof);
    end
    n_tests++;
    if (out_pixel !== 8'd0 || out_dilate !== 8'd0 || out_erode !== 8'd0) begin
      n_fails++;
      $display("FAIL reset_data: got %0d/%0d/%0d, want 0/0/0", out_pixel, out_dilate, out_erode);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flat();
    frame_t f;
    int base;
    foreach (f[k]) f[k] = 8'd50;
    run_frame(f, 0, base);
    n_tests++;
    if (beat_cnt - base != N) begin
      n_fails++;
      $display("FAIL flat_count: got %0d triples, want %0d", beat_cnt - base, N);
    end
    n_tests++;
    if (rx[base].sof !== 1'b1 || rx[base+N-1].eof !== 1'b1) begin
      n_fails++;
      $display("FAIL flat_sof_eof: got sof=%0b eof=%0b, want 1 1", rx[base].sof, rx[base+N-1].eof);
    end
  endtask

  task automatic test_impulse();
    frame_t f;
    int base;
    foreach (f[k]) f[k] = 8'd10;
    f[1*W + 1] = 8'd200;
    run_frame(f, 0, base);
    n_tests++;
    if (rx[base + 2*W + 2].dil !== 8'd200 || rx[base + 3].dil !== 8'd10) begin
      n_fails++;
      $display("FAIL impulse_dilate: got (2,2)=%0d (0,3)=%0d, want 200 10", rx[base + 2*W + 2].dil, rx[base + 3].dil);
    end
    n_tests++;
    if (rx[base + 5].pix !== 8'd200 || rx[base + 5].ero !== 8'd10) begin
      n_fails++;
      $display("FAIL impulse_centre: got pix=%0d ero=%0d, want 200 10", rx[base + 5].pix, rx[base + 5].ero);
    end
  endtask

  task automatic test_corner();
    frame_t f;
    int base;
    logic [7:0] want_d00, want_e23;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) f[r*W + c] = 8'(10*r + c);
`ifdef MORPH_CROSS_SE_EN
    want_d00 = 8'd10;
    want_e23 = 8'd13;
`else
    want_d00 = 8'd11;
    want_e23 = 8'd12;
`endif
    run_frame(f, 0, base);
    n_tests++;
    if (rx[base].dil !== want_d00 || rx[base].ero !== 8'd0) begin
      n_fails++;
      $display("FAIL corner_00: got dil=%0d ero=%0d, want %0d 0", rx[base].dil, rx[base].ero, want_d00);
    end
    n_tests++;
    if (rx[base+N-1].dil !== 8'd23 || rx[base+N-1].ero !== want_e23) begin
      n_fails++;
      $display("FAIL corner_23: got dil=%0d ero=%0d, want 23 %0d", rx[base+N-1].dil, rx[base+N-1].ero, want_e23);
    end
  endtask

  task automatic test_backpressure();
    frame_t f;
    int base;
    foreach (f[k]) f[k] = 8'($urandom_range(0, 255));
    ready_mode = 1;
    run_frame(f, 30, base);
    ready_mode = 0;
    n_tests++;
    if (beat_cnt - base != N) begin
      n_fails++;
      $display("FAIL backpressure_count: got %0d triples, want %0d", beat_cnt - base, N);
    end
  endtask

  task automatic test_reset_mid();
    frame_t f;
    int base;
    foreach (f[k]) f[k] = 8'd33;
    drive_pixels(f, 5, 0);
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_ctrl: got valid=%0b ready=%0b, want 0 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (f[k]) f[k] = 8'd77;
    run_frame(f, 0, base);
    n_tests++;
    if (beat_cnt - base != N || rx[base].sof !== 1'b1 || rx[base+N-1].eof !== 1'b1) begin
      n_fails++;
      $display("FAIL midreset_frame: got %0d triples sof=%0b eof=%0b, want %0d 1 1",
               beat_cnt - base, rx[base].sof, rx[base+N-1].eof, N);
    end
  endtask

  task automatic test_cross();
    frame_t f;
    int base;
    logic [7:0] want_11;
    foreach (f[k]) f[k] = 8'd10;
    f[0] = 8'd200;
`ifdef MORPH_CROSS_SE_EN
    want_11 = 8'd10;
`else
    want_11 = 8'd200;
`endif
    run_frame(f, 0, base);
    n_tests++;
    if (rx[base + W + 1].dil !== want_11) begin
      n_fails++;
      $display("FAIL cross_11: got dil=%0d, want %0d", rx[base + W + 1].dil, want_11);
    end
    n_tests++;
    if (rx[base + 1].dil !== 8'd200) begin
      n_fails++;
      $display("FAIL cross_01: got dil=%0d, want 200", rx[base + 1].dil);
    end
  endtask

  task automatic test_back_to_back();
    frame_t fa, fb;
    int base;
    foreach (fa[k]) fa[k] = 8'($urandom_range(0, 255));
    foreach (fb[k]) fb[k] = 8'($urandom_range(0, 255));
    base = beat_cnt;
    push_frame(fa);
    push_frame(fb);
    drive_pixels(fa, N, 0);
    drive_pixels(fb, N, 0);
    drain();
    n_tests++;
    if (beat_cnt - base != 2*N || rx[base + N].sof !== 1'b1) begin
      n_fails++;
      $display("FAIL b2b_frames: got %0d triples sof2=%0b, want %0d 1", beat_cnt - base, rx[base + N].sof, 2*N);
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_impulse();
    test_corner();
    test_backpressure();
    test_reset_mid();
    test_cross();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
